// File: rtl/ext_mem_responder.sv
// Wait-stated responder for the core's ext_mem port: word RAM below MMIO_BASE, LED/switch/cycle-counter page above.
// Latency: ext_mem_ready pulses WAIT_CYCLES+1 cycles after the first request cycle; at least one idle cycle between transactions.
// Backpressure: the core holds its request until ready; dropping it while waiting aborts the access and sets err.
module ext_mem_responder #(
   parameter int unsigned       ADDR_W      = 16,
   parameter int unsigned       DEPTH_WORDS = 4096,
   parameter int unsigned       WAIT_CYCLES = 2,
   parameter logic [ADDR_W-1:0] MMIO_BASE   = 16'hF000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] ext_mem_addr,
   input  logic [31:0]       ext_mem_wdata,
   input  logic              ext_mem_write,
   input  logic              ext_mem_read,
   output logic [31:0]       ext_mem_rdata,
   output logic              ext_mem_ready,
   input  logic [15:0]       sw_in,
   output logic [15:0]       led_out,
   output logic              err
);
   localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
   localparam int unsigned RAM_BYTES = DEPTH_WORDS * 4;
   // Counter load value; unused when WAIT_CYCLES is 0 because IDLE jumps straight to RESP
   localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state, state_d;
   logic [3:0]  cnt, cnt_d;
   logic        go_resp, abort, accept, commit;
   logic        req, rd_op;
   logic        is_ram, in_mmio, sel_led, sel_sw, sel_cyc, is_hole, bad_req;
   logic [31:0] mmio_word;
   logic [IDX_W-1:0] idx;
   logic [31:0] rd_mux, rdata_q, cyc_q;
   logic [15:0] led_q, sw_s1, sw_s2;
   logic        err_q;
   logic [31:0] ram [DEPTH_WORDS];

   // Address decode works on the word address; the byte offset only feeds the error flag
   assign req       = ext_mem_read | ext_mem_write;
   assign rd_op     = ext_mem_read & ~ext_mem_write;   // read+write completes as a write
   assign idx       = ext_mem_addr[IDX_W+1:2];
   assign is_ram    = 32'(ext_mem_addr) < RAM_BYTES;
   assign in_mmio   = ext_mem_addr >= MMIO_BASE;
   assign mmio_word = 32'(ext_mem_addr[ADDR_W-1:2] - MMIO_BASE[ADDR_W-1:2]);
   assign sel_led   = in_mmio && (mmio_word == 32'd0);
   assign sel_sw    = in_mmio && (mmio_word == 32'd1);
   assign sel_cyc   = in_mmio && (mmio_word == 32'd2);
   assign is_hole   = ~is_ram & ~sel_led & ~sel_sw & ~sel_cyc;
   assign bad_req   = is_hole | (ext_mem_addr[1:0] != 2'b00) | (ext_mem_read & ext_mem_write);

   assign accept = (state == IDLE) & req;
   assign commit = (state == RESP) & ext_mem_write;

   assign ext_mem_ready = (state == RESP);
   assign ext_mem_rdata = rdata_q;
   assign led_out       = led_q;
   assign err           = err_q;

   // Read-data source for the addressed word, captured on the edge that enters RESP
   always_comb begin
      rd_mux = 32'h0;
      if (is_ram)       rd_mux = ram[idx];
      else if (sel_led) rd_mux = {16'h0, led_q};
      else if (sel_sw)  rd_mux = {16'h0, sw_s2};
      else if (sel_cyc) rd_mux = cyc_q;
   end

   // Next-state logic: wait-state countdown, abort on dropped request, single RESP cycle
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      go_resp = 1'b0;
      abort   = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               if (WAIT_CYCLES == 0) begin
                  state_d = RESP;
                  go_resp = 1'b1;
               end else begin
                  state_d = WAIT;
                  cnt_d   = WAIT_LOAD;
               end
            end
         end
         WAIT: begin
            if (!req) begin
               state_d = IDLE;
               abort   = 1'b1;
            end else if (cnt == 4'd0) begin
               state_d = RESP;
               go_resp = 1'b1;
            end else begin
               cnt_d = cnt - 4'd1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM state, wait counter and read data (non-zero only during RESP)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         rdata_q <= 32'h0;
      end else begin
         state   <= state_d;
         cnt     <= cnt_d;
         rdata_q <= (go_resp && rd_op) ? rd_mux : 32'h0;
      end
   end

   // MMIO registers, switch synchroniser, free-running counter and sticky error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led_q <= 16'h0;
         cyc_q <= 32'h0;
         sw_s1 <= 16'h0;
         sw_s2 <= 16'h0;
         err_q <= 1'b0;
      end else begin
         sw_s1 <= sw_in;
         sw_s2 <= sw_s1;
         if (commit && sel_led) led_q <= ext_mem_wdata[15:0];
         if (commit && sel_cyc) cyc_q <= ext_mem_wdata;
         else                   cyc_q <= cyc_q + 32'd1;
         if ((accept && bad_req) || abort) err_q <= 1'b1;
      end
   end

   // RAM write port; contents survive reset by design
   always_ff @(posedge clk) begin
      if (commit && is_ram) ram[idx] <= ext_mem_wdata;
   end
endmodule

// File: tb/tb_ext_mem_responder.sv
// Bench for ext_mem_responder: directed table, multi-cycle corner sequences, randomized traffic against an address-level model.
// Latency: checks ready at T0+WAIT_CYCLES+1 for the default build and T0+1 for a zero-wait instance.
// Backpressure: requests are held through the ready cycle and dropped after it, as the core does.
module tb_ext_mem_responder;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [15:0] addr, sw, led;
   logic [31:0] wdata, rdata;
   logic        wr, rd, ready, err;
   logic [15:0] addr0, led0;
   logic [31:0] wdata0, rdata0;
   logic        wr0, rd0, ready0, err0;

   ext_mem_responder dut (
      .clk(clk), .rst_n(rst_n), .ext_mem_addr(addr), .ext_mem_wdata(wdata),
      .ext_mem_write(wr), .ext_mem_read(rd), .ext_mem_rdata(rdata), .ext_mem_ready(ready),
      .sw_in(sw), .led_out(led), .err(err));

   ext_mem_responder #(.WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .ext_mem_addr(addr0), .ext_mem_wdata(wdata0),
      .ext_mem_write(wr0), .ext_mem_read(rd0), .ext_mem_rdata(rdata0), .ext_mem_ready(ready0),
      .sw_in(sw), .led_out(led0), .err(err0));

   int checks = 0;
   int passes = 0;
   int edge_n = 0;
   always @(posedge clk) edge_n <= edge_n + 1;

   // Reference model: RAM words seen so far, LED, switches, counter as (value, edge it was valid after)
   logic [31:0] mem_m [int];
   logic [15:0] led_m, sw_m;
   logic        err_m;
   logic [31:0] cyc_val;
   int          cyc_edge;

   typedef struct {
      logic        r;
      logic        w;
      logic [15:0] a;
      logic [31:0] d;
      logic [31:0] exp_rdata;
      logic        exp_err;
      logic [15:0] exp_led;
   } vec_t;
   vec_t tbl [16];
   vec_t tbl0 [4];

   logic [31:0] got;
   logic        flag;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act === expv) passes++;
      else $display("FAIL %s: got %h, expected %h", name, act, expv);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      rd = 1'b0; wr = 1'b0; rd0 = 1'b0; wr0 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc_edge = edge_n;
      cyc_val  = 32'h0;
      err_m    = 1'b0;
      led_m    = 16'h0;
   endtask

   // Issue one request on the default instance, hold it through ready, drop it afterwards
   task automatic do_txn(input logic r, input logic w, input logic [15:0] a, input logic [31:0] d,
                         output logic [31:0] g, output int lat, output int r_edge);
      logic idle_bad;
      idle_bad = 1'b0;
      rd = r; wr = w; addr = a; wdata = d;
      g = 32'h0; lat = 0; r_edge = 0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         if (ready) begin
            lat = n; g = rdata; r_edge = edge_n;
            break;
         end
         if (rdata !== 32'h0) idle_bad = 1'b1;
      end
      if (lat == 0) begin
         checks++;
         $display("FAIL ready_timeout: no ready within 40 cycles for addr %h", a);
      end
      chk("rdata_outside_ready", 32'(idle_bad), 32'h0);
      @(posedge clk); #1;
      chk("ready_single_cycle", {31'h0, ready}, 32'h0);
      chk("rdata_after_ready", rdata, 32'h0);
      rd = 1'b0; wr = 1'b0;
   endtask

   // Transaction plus model prediction and model update
   task automatic run(input logic r, input logic w, input logic [15:0] a, input logic [31:0] d,
                      input string tag, output logic [31:0] g);
      logic [15:0] word;
      logic        hole, known;
      logic [31:0] expv;
      int          lat, re, k;
      word = {a[15:2], 2'b00};
      k    = int'(word[15:2]);
      hole = !((word < 16'h4000) || word == 16'hF000 || word == 16'hF004 || word == 16'hF008);
      do_txn(r, w, a, d, g, lat, re);
      chk({tag, "_latency"}, 32'(lat), 32'd3);
      known = 1'b1;
      expv  = 32'h0;
      if (r && !w) begin
         if (word < 16'h4000) begin
            known = mem_m.exists(k);
            if (known) expv = mem_m[k];
         end
         else if (word == 16'hF000) expv = {16'h0, led_m};
         else if (word == 16'hF004) expv = {16'h0, sw_m};
         else if (word == 16'hF008) expv = cyc_val + 32'(re - 1 - cyc_edge);
      end
      if (known) chk({tag, "_rdata"}, g, expv);
      if (w) begin
         if (word < 16'h4000) mem_m[k] = d;
         else if (word == 16'hF000) led_m = d[15:0];
         else if (word == 16'hF008) begin
            cyc_val  = d;
            cyc_edge = re + 1;
         end
      end
      if ((r && w) || a[1:0] != 2'b00 || hole) err_m = 1'b1;
      chk({tag, "_err"}, {31'h0, err}, {31'h0, err_m});
      chk({tag, "_led"}, {16'h0, led}, {16'h0, led_m});
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] ra;
      logic [31:0] rdv;
      int          cat, op;

      tbl[0]  = '{1'b0, 1'b1, 16'h0010, 32'hA5A5_1234, 32'h0,          1'b0, 16'h0000};
      tbl[1]  = '{1'b1, 1'b0, 16'h0010, 32'h0,         32'hA5A5_1234,  1'b0, 16'h0000};
      tbl[2]  = '{1'b0, 1'b1, 16'hF000, 32'h0000_BEEF, 32'h0,          1'b0, 16'hBEEF};
      tbl[3]  = '{1'b1, 1'b0, 16'hF000, 32'h0,         32'h0000_BEEF,  1'b0, 16'hBEEF};
      tbl[4]  = '{1'b1, 1'b0, 16'hF004, 32'h0,         32'h0000_00FF,  1'b0, 16'hBEEF};
      tbl[5]  = '{1'b0, 1'b1, 16'hF004, 32'h1234_5678, 32'h0,          1'b0, 16'hBEEF};
      tbl[6]  = '{1'b1, 1'b0, 16'hF004, 32'h0,         32'h0000_00FF,  1'b0, 16'hBEEF};
      tbl[7]  = '{1'b0, 1'b1, 16'h3FFC, 32'hDEAD_BEEF, 32'h0,          1'b0, 16'hBEEF};
      tbl[8]  = '{1'b1, 1'b0, 16'h3FFC, 32'h0,         32'hDEAD_BEEF,  1'b0, 16'hBEEF};
      tbl[9]  = '{1'b1, 1'b0, 16'h8000, 32'h0,         32'h0,          1'b1, 16'hBEEF};
      tbl[10] = '{1'b1, 1'b1, 16'h0020, 32'h7,         32'h0,          1'b1, 16'hBEEF};
      tbl[11] = '{1'b1, 1'b0, 16'h0020, 32'h0,         32'h7,          1'b1, 16'hBEEF};
      tbl[12] = '{1'b0, 1'b1, 16'h4000, 32'h55,        32'h0,          1'b1, 16'hBEEF};
      tbl[13] = '{1'b1, 1'b0, 16'h4000, 32'h0,         32'h0,          1'b1, 16'hBEEF};
      tbl[14] = '{1'b1, 1'b0, 16'hF00C, 32'h0,         32'h0,          1'b1, 16'hBEEF};
      tbl[15] = '{1'b1, 1'b0, 16'h0012, 32'h0,         32'hA5A5_1234,  1'b1, 16'hBEEF};

      tbl0[0] = '{1'b0, 1'b1, 16'h0000, 32'h1111_1111, 32'h0,          1'b0, 16'h0};
      tbl0[1] = '{1'b0, 1'b1, 16'h0004, 32'h2222_2222, 32'h0,          1'b0, 16'h0};
      tbl0[2] = '{1'b1, 1'b0, 16'h0000, 32'h0,         32'h1111_1111,  1'b0, 16'h0};
      tbl0[3] = '{1'b1, 1'b0, 16'h0004, 32'h0,         32'h2222_2222,  1'b0, 16'h0};

      addr = 16'h0; wdata = 32'h0; rd = 1'b0; wr = 1'b0; sw = 16'h0; sw_m = 16'h0;
      addr0 = 16'h0; wdata0 = 32'h0; rd0 = 1'b0; wr0 = 1'b0;

      // Reset state
      @(posedge clk); #1;
      chk("reset_ready", {31'h0, ready}, 32'h0);
      chk("reset_rdata", rdata, 32'h0);
      chk("reset_led", {16'h0, led}, 32'h0);
      chk("reset_err", {31'h0, err}, 32'h0);
      sw = 16'h00FF; sw_m = 16'h00FF;
      do_reset();

      // Counter starts from zero at reset release
      run(1'b1, 1'b0, 16'hF008, 32'h0, "cyc_after_reset", got);
      chk("cyc_after_reset_abs", got, 32'd2);

      // Directed vectors
      for (int i = 0; i < 16; i++) begin
         run(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, $sformatf("vec%0d", i), got);
         chk($sformatf("vec%0d_tbl_rdata", i), got, tbl[i].exp_rdata);
         chk($sformatf("vec%0d_tbl_err", i), {31'h0, err}, {31'h0, tbl[i].exp_err});
         chk($sformatf("vec%0d_tbl_led", i), {16'h0, led}, {16'h0, tbl[i].exp_led});
      end

      // Counter load, idle gap, and wrap
      run(1'b0, 1'b1, 16'hF008, 32'd5, "cyc_load", got);
      repeat (4) begin @(posedge clk); #1; end
      run(1'b1, 1'b0, 16'hF008, 32'h0, "cyc_idle4", got);
      chk("cyc_idle4_abs", got, 32'd11);
      run(1'b0, 1'b1, 16'hF008, 32'hFFFF_FFFF, "cyc_wrap_load", got);
      run(1'b1, 1'b0, 16'hF008, 32'h0, "cyc_wrap", got);
      chk("cyc_wrap_abs", got, 32'd1);

      // Reset asserted while waiting: no ready, no commit, registers cleared
      run(1'b0, 1'b1, 16'h0030, 32'h1111, "rst_pre", got);
      rd = 1'b0; wr = 1'b1; addr = 16'h0030; wdata = 32'h2222;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_ready", {31'h0, ready}, 32'h0);
      chk("rst_mid_led", {16'h0, led}, 32'h0);
      chk("rst_mid_err", {31'h0, err}, 32'h0);
      chk("rst_mid_rdata", rdata, 32'h0);
      wr = 1'b0;
      flag = 1'b0;
      repeat (3) begin @(posedge clk); #1; if (ready) flag = 1'b1; end
      rst_n = 1'b1;
      cyc_edge = edge_n; cyc_val = 32'h0; err_m = 1'b0; led_m = 16'h0;
      chk("rst_mid_no_ready", 32'(flag), 32'h0);
      run(1'b1, 1'b0, 16'h0030, 32'h0, "rst_no_commit", got);
      chk("rst_no_commit_abs", got, 32'h1111);
      run(1'b0, 1'b1, 16'h0030, 32'h2222, "reissue_wr", got);
      run(1'b1, 1'b0, 16'h0030, 32'h0, "reissue_rd", got);
      chk("reissue_abs", got, 32'h2222);

      // Abort: write dropped while waiting
      run(1'b0, 1'b1, 16'h0040, 32'h3333, "abort_pre", got);
      rd = 1'b0; wr = 1'b1; addr = 16'h0040; wdata = 32'h4444;
      @(posedge clk); #1;
      wr = 1'b0;
      flag = 1'b0;
      repeat (5) begin @(posedge clk); #1; if (ready) flag = 1'b1; end
      chk("abort_no_ready", 32'(flag), 32'h0);
      chk("abort_err", {31'h0, err}, 32'h1);
      err_m = 1'b1;
      run(1'b1, 1'b0, 16'h0040, 32'h0, "abort_mem", got);
      chk("abort_mem_abs", got, 32'h3333);

      // Zero-wait instance: ready at T0+1, idle cycle, next ready two cycles later
      for (int i = 0; i < 4; i++) begin
         rd0 = tbl0[i].r; wr0 = tbl0[i].w; addr0 = tbl0[i].a; wdata0 = tbl0[i].d;
         @(posedge clk); #1;
         chk($sformatf("w0_%0d_ready", i), {31'h0, ready0}, 32'h1);
         chk($sformatf("w0_%0d_rdata", i), rdata0, tbl0[i].exp_rdata);
         @(posedge clk); #1;
         chk($sformatf("w0_%0d_gap", i), {31'h0, ready0}, 32'h0);
      end
      rd0 = 1'b0; wr0 = 1'b0;

      // Randomized traffic against the model
      do_reset();
      for (int i = 0; i < 80; i++) begin
         cat = int'($urandom_range(0, 9));
         if (cat <= 5)      ra = 16'($urandom_range(0, 31) * 4);
         else if (cat == 6) ra = 16'hF000;
         else if (cat == 7) ra = 16'hF004;
         else if (cat == 8) ra = 16'hF008;
         else if ($urandom_range(0, 1) == 0) ra = 16'($urandom_range(16'h4000, 16'hEFFF)) & 16'hFFFC;
         else               ra = 16'($urandom_range(16'hF00C, 16'hFFFF)) & 16'hFFFC;
         if ($urandom_range(0, 15) == 0) ra[1:0] = 2'($urandom_range(1, 3));
         if ($urandom_range(0, 3) == 0) begin
            sw = 16'($urandom);
            sw_m = sw;
         end
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         op  = int'($urandom_range(0, 15));
         rdv = $urandom;
         run(op == 0 || op < 8, op == 0 || op >= 8, ra, rdv, $sformatf("rnd%0d", i), got);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
